// File: rtl/ram_sp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_pkg
//  Description : Shared definitions for the single-port sync-read/write RAM
//                initiator: default bus widths and controller state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_sp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_LEN_WIDTH  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_WRITE = ST_WRITE,
        S_READ  = ST_READ,
        S_DRAIN = ST_DRAIN
    } state_t;

endpackage : ram_sp_pkg
`default_nettype wire

// File: rtl/ram_sp_sr_sw_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_sr_sw_ctrl_if
//  Description : Client-side bundle of the RAM initiator: burst request,
//                write-beat stream, read-beat stream and status.
//                master = client datapath, slave = controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_sp_sr_sw_ctrl_if
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  err;

    modport master (
        output req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, busy, err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, busy, err
    );
endinterface : ram_sp_sr_sw_ctrl_if
`default_nettype wire

// File: rtl/ram_sp_ctrl_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_ctrl_addr_gen
//  Description : Burst address generator. Loads a start address and beat
//                count, steps the address (wrapping at 2**ADDR_WIDTH) and
//                counts down remaining beats.
//  Ports       : clk, rst        clock / sync active-high reset
//                i_load          load i_load_addr / i_load_len
//                i_step          advance to the next beat
//                o_addr          address of the current beat
//                o_addr_inc      address of the following beat
//                o_last          current beat is the final one
//  Revision    : 1.0  initial release
// ============================================================================
module ram_sp_ctrl_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [ADDR_WIDTH-1:0] i_load_addr,
    input  wire logic [LEN_WIDTH-1:0]  i_load_len,
    input  wire logic                  i_step,
    output logic      [ADDR_WIDTH-1:0] o_addr,
    output logic      [ADDR_WIDTH-1:0] o_addr_inc,
    output logic                       o_last
);
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_load_addr;
            r_remain <= i_load_len;
        end else if (i_step) begin
            r_addr   <= o_addr_inc;
            r_remain <= r_remain - LEN_WIDTH'(1);
        end
    end

    // Natural overflow of the adder gives the modulo-2**ADDR_WIDTH wrap.
    assign o_addr_inc = r_addr + ADDR_WIDTH'(1);
    assign o_addr     = r_addr;
    assign o_last     = (r_remain == '0);
endmodule : ram_sp_ctrl_addr_gen
`default_nettype wire

// File: rtl/ram_sp_sr_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_sp_sr_sw_ctrl
//  Description : Initiator for a single-port synchronous RAM. Turns burst
//                requests into RAM cycles (cs/we/oe/address, shared data bus)
//                and returns read data as a registered, non-stalling stream.
//  Ports       : clk, rst        clock / sync active-high reset
//                bus (slave)     request, write-beat, read-beat, busy, err
//                ram_address     registered RAM address
//                ram_data        bidirectional data, driven only on writes
//                ram_cs/we/oe    registered RAM controls
//  Options     : RAM_SP_CTRL_BOUND_CHECK_EN - reject bursts running past the
//                top of the address space (err pulse, no RAM activity);
//                undefined: addresses wrap and err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_sp_sr_sw_ctrl
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ram_sp_sr_sw_ctrl_if.slave         bus,
    output logic      [ADDR_WIDTH-1:0] ram_address,
    inout  wire       [DATA_WIDTH-1:0] ram_data,
    output logic                       ram_cs,
    output logic                       ram_we,
    output logic                       ram_oe
);
    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_wr_ready;
    logic                  r_busy;
    logic                  r_cap;       // a read beat is on the RAM bus this cycle
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_ram_cs;
    logic                  r_ram_we;
    logic                  r_ram_oe;
    logic [ADDR_WIDTH-1:0] r_ram_address;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_req_hs;
    logic                  w_wr_hs;
    logic                  w_accept;
    logic                  w_step;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_last;

    assign w_req_hs = bus.req_valid && r_req_ready;
    assign w_wr_hs  = bus.wr_valid && r_wr_ready;

`ifdef RAM_SP_CTRL_BOUND_CHECK_EN
    logic [ADDR_WIDTH:0] w_end_addr;
    logic                w_oob;
    logic                r_err;

    // A carry out of start+len means the burst would cross the top address.
    assign w_end_addr = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(bus.req_len);
    assign w_oob      = w_end_addr[ADDR_WIDTH];
    assign w_accept   = w_req_hs && !w_oob;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_req_hs && w_oob;
        end
    end

    assign bus.err = r_err;
`else
    assign w_accept = w_req_hs;
    assign bus.err  = 1'b0;
`endif

    // In READ every cycle issues a beat; advance unless this was the last one.
    assign w_step = ((r_state == S_WRITE) && w_wr_hs) ||
                    ((r_state == S_READ) && !w_last);

    ram_sp_ctrl_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_addr (bus.req_addr),
        .i_load_len  (bus.req_len),
        .i_step      (w_step),
        .o_addr      (w_addr),
        .o_addr_inc  (w_addr_inc),
        .o_last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b0;
            r_wr_ready    <= 1'b0;
            r_busy        <= 1'b0;
            r_cap         <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_ram_cs      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_oe      <= 1'b0;
            r_ram_address <= '0;
            r_wdata       <= '0;
        end else begin
            // Read return pipeline: issued in N, on the bus in N+1,
            // sampled at the end of N+1, presented in N+2.
            r_cap      <= (r_state == S_READ);
            r_rd_valid <= r_cap;
            if (r_cap) begin
                r_rd_data <= ram_data;
            end

            case (r_state)
                S_IDLE: begin
                    r_ram_cs <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_ram_oe <= 1'b0;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.req_we) begin
                            r_state    <= S_WRITE;
                            r_wr_ready <= 1'b1;
                        end else begin
                            // First read beat is issued straight from the
                            // accept edge so it appears in the next cycle.
                            r_state       <= S_READ;
                            r_ram_cs      <= 1'b1;
                            r_ram_oe      <= 1'b1;
                            r_ram_address <= bus.req_addr;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                S_WRITE: begin
                    r_ram_oe <= 1'b0;
                    if (w_wr_hs) begin
                        r_ram_cs      <= 1'b1;
                        r_ram_we      <= 1'b1;
                        r_ram_address <= w_addr;
                        r_wdata       <= bus.wr_data;
                        if (w_last) begin
                            r_state     <= S_IDLE;
                            r_wr_ready  <= 1'b0;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end
                    end else begin
                        r_ram_cs <= 1'b0;
                        r_ram_we <= 1'b0;
                    end
                end

                S_READ: begin
                    r_ram_cs <= 1'b1;
                    r_ram_we <= 1'b0;
                    r_ram_oe <= 1'b1;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_ram_address <= w_addr_inc;
                    end
                end

                S_DRAIN: begin
                    // cs/oe were held through this cycle so the RAM drives
                    // the final beat; release them now.
                    r_state     <= S_IDLE;
                    r_ram_cs    <= 1'b0;
                    r_ram_oe    <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The driver enable is the ram_we flop itself, so the bus is released
    // in the same cycle the RAM is told to read.
    assign ram_data = (r_ram_cs && r_ram_we) ? r_wdata : {DATA_WIDTH{1'bz}};

    assign ram_address   = r_ram_address;
    assign ram_cs        = r_ram_cs;
    assign ram_we        = r_ram_we;
    assign ram_oe        = r_ram_oe;
    assign bus.req_ready = r_req_ready;
    assign bus.wr_ready  = r_wr_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.busy      = r_busy;
endmodule : ram_sp_sr_sw_ctrl
`default_nettype wire

// File: tb/tb_ram_sp_sr_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_sp_sr_sw_ctrl
//  Description : Directed self-checking bench for ram_sp_sr_sw_ctrl with a
//                behavioural single-port synchronous RAM on the pin side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_sp_sr_sw_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ram_address;
    wire  [7:0] ram_data;
    logic       ram_cs;
    logic       ram_we;
    logic       ram_oe;

    int checks   = 0;
    int failures = 0;

    ram_sp_sr_sw_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) bus ();

    ram_sp_sr_sw_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .LEN_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: captures a read at the edge, drives it the next cycle.
    logic [7:0] mem [0:255];
    logic [7:0] r_q;
    logic       r_tb_cap;
    wire        w_tb_drv = r_tb_cap && ram_oe && !ram_we;
    assign ram_data = w_tb_drv ? r_q : 8'hzz;

    always @(posedge clk) begin
        if (rst) begin
            r_tb_cap <= 1'b0;
        end else if (ram_cs && !ram_we) begin
            r_q      <= mem[ram_address];
            r_tb_cap <= 1'b1;
        end else begin
            r_tb_cap <= 1'b0;
        end
        if (!rst && ram_cs && ram_we) begin
            mem[ram_address] <= ram_data;
        end
    end

    // Bus ownership: never both sides driving, and we never without cs.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ({w_tb_drv && ram_we, ram_we && !ram_cs} === 2'b00) else begin
                failures++;
                $error("FAIL bus_turnaround: observed collision/we_no_cs=%b expected=00",
                       {w_tb_drv && ram_we, ram_we && !ram_cs});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, presents one request, returns in the
    // cycle after the accept edge.
    task automatic do_req(input logic we, input logic [7:0] a, input logic [3:0] l);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_len   = l;
        tick();
        bus.req_valid = 1'b0;
    endtask

    logic [7:0] d2 [4];
    logic [7:0] d3 [4];
    logic [7:0] a3 [4];
    logic       seen;

    initial begin
        d2[0] = 8'h11; d2[1] = 8'h22; d2[2] = 8'h33; d2[3] = 8'h44;
        d3[0] = 8'h31; d3[1] = 8'h32; d3[2] = 8'h33; d3[3] = 8'h34;
        a3[0] = 8'hFE; a3[1] = 8'hFF; a3[2] = 8'h00; a3[3] = 8'h01;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
        bus.wr_valid  = 1'b0; bus.wr_data = '0;

        // Reset state
        tick(); tick();
        chk("reset_ctrl", {24'd0, bus.req_ready, bus.wr_ready, bus.rd_valid, bus.busy,
                           bus.err, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("reset_addr", {24'd0, ram_address}, 32'd0);
        chk("reset_rd_data", {24'd0, bus.rd_data}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // 1: single write 0x10 <= A5, single read back
        do_req(1'b1, 8'h10, 4'd0);
        chk("t1_wr_ready", {30'd0, bus.wr_ready, bus.busy}, 32'b11);
        bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_valid = 1'b0;
        chk("t1_wr_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
        chk("t1_wr_addr", {24'd0, ram_address}, 32'h10);
        chk("t1_wr_bus", {24'd0, ram_data}, 32'hA5);
        do_req(1'b0, 8'h10, 4'd0);
        chk("t1_rd_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
        chk("t1_rd_valid_a1", {31'd0, bus.rd_valid}, 32'd0);
        tick();
        chk("t1_rd_valid_a2", {31'd0, bus.rd_valid}, 32'd0);
        tick();
        chk("t1_rd_valid_a3", {31'd0, bus.rd_valid}, 32'd1);
        chk("t1_rd_data", {24'd0, bus.rd_data}, 32'hA5);
        tick();
        chk("t1_rd_valid_a4", {31'd0, bus.rd_valid}, 32'd0);

        // 2: gapped write burst @0x20, then read burst
        do_req(1'b1, 8'h20, 4'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_gap_cs", {31'd0, ram_cs}, 32'd0);
            bus.wr_valid = 1'b1; bus.wr_data = d2[i];
            tick();
            bus.wr_valid = 1'b0;
            chk("t2_hs_cs_we", {30'd0, ram_cs, ram_we}, 32'b11);
            chk("t2_hs_addr", {24'd0, ram_address}, 32'h20 + i);
        end
        chk("t2_end_ready", {30'd0, bus.req_ready, bus.wr_ready}, 32'b10);
        do_req(1'b0, 8'h20, 4'd3);
        tick();
        chk("t2_rd_early", {31'd0, bus.rd_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_rd_valid", {31'd0, bus.rd_valid}, 32'd1);
            chk("t2_rd_data", {24'd0, bus.rd_data}, {24'd0, d2[i]});
        end
        tick();
        chk("t2_rd_done", {30'd0, bus.rd_valid, bus.busy}, 32'd0);

        // 3: write burst crossing the top of the address space
        do_req(1'b1, 8'hFE, 4'd3);
`ifdef RAM_SP_CTRL_BOUND_CHECK_EN
        chk("t3_err", {31'd0, bus.err}, 32'd1);
        chk("t3_idle", {28'd0, bus.wr_ready, bus.busy, ram_cs, bus.req_ready}, 32'b0001);
        bus.wr_valid = 1'b1; bus.wr_data = 8'h99;
        tick();
        chk("t3_err_pulse", {31'd0, bus.err}, 32'd0);
        chk("t3_no_cycle", {30'd0, bus.wr_ready, ram_cs}, 32'd0);
        tick();
        chk("t3_no_cycle2", {30'd0, bus.wr_ready, ram_cs}, 32'd0);
        bus.wr_valid = 1'b0;
`else
        chk("t3_err_tied", {31'd0, bus.err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_data = d3[i];
            tick();
            chk("t3_wrap_addr", {24'd0, ram_address}, {24'd0, a3[i]});
        end
        bus.wr_valid = 1'b0;
        do_req(1'b0, 8'hFE, 4'd3);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_rd_data", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, d3[i]});
        end
`endif

        // 5 + 6: req_valid held through a write, read follows immediately
        tick();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 8'h40; bus.req_len = 4'd1;
        tick();
        bus.req_we = 1'b0;
        chk("t5_busy_noready", {30'd0, bus.busy, bus.req_ready}, 32'b10);
        bus.wr_valid = 1'b1; bus.wr_data = 8'h55;
        tick();
        chk("t5_noready_mid", {31'd0, bus.req_ready}, 32'd0);
        bus.wr_data = 8'h66;
        tick();
        bus.wr_valid = 1'b0;
        chk("t5_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        chk("t5_last_write", {22'd0, ram_cs, ram_we, ram_address}, {22'd0, 2'b11, 8'h41});
        tick();
        bus.req_valid = 1'b0;
        chk("t5_accepted", {30'd0, bus.busy, bus.req_ready}, 32'b10);
        chk("t6_read_ctrl", {21'd0, ram_cs, ram_we, ram_oe, ram_address},
                            {21'd0, 3'b101, 8'h40});
        tick(); tick();
        chk("t6_rd0", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h55});
        tick();
        chk("t6_rd1", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h66});

        // 4: reset in the cycle after the second issue of a len-7 read
        do_req(1'b0, 8'h20, 4'd7);
        tick();
        tick();
        rst = 1'b1;
        chk("t4_beat0", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h11});
        tick();
        chk("t4_reset_ctrl", {24'd0, bus.req_ready, bus.wr_ready, bus.rd_valid, bus.busy,
                              bus.err, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("t4_reset_data", {16'd0, ram_address, bus.rd_data}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.rd_valid | ram_cs;
        end
        chk("t4_no_more_beats", {31'd0, seen}, 32'd0);
        chk("t4_ready_again", {31'd0, bus.req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_ram_sp_sr_sw_ctrl
`default_nettype wire
